// File: rtl/pad_descr_lock_ctrl.sv
// Lock controller for the pad-path self-synchronous descrambler: reset, LFSR fill, hunt, lock, resync.
// Define PAD_DESCR_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to zero.
module pad_descr_lock_ctrl #(
    parameter logic [28:0] IDLE_WORD    = 29'h0AAAAAAA,
    parameter int unsigned FLUSH_FRAMES = 2,
    parameter int unsigned LOCK_CNT     = 8,
    parameter int unsigned ERR_THRESH   = 4,
    parameter int unsigned WINDOW       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        bypass_req,
    input  logic        frame_in,
    input  logic [28:0] descr_data,
    output logic        descr_rst,
    output logic        descr_bypass,
    output logic        descr_frame,
    output logic        locked,
    output logic [2:0]  state,
    output logic [15:0] err_cnt,
    output logic [7:0]  relock_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_HUNT   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_RESYNC = 3'd4
    } state_e;

    localparam logic [7:0]  FLUSH_N = FLUSH_FRAMES[7:0];
    localparam logic [7:0]  LOCK_N  = LOCK_CNT[7:0];
    localparam logic [7:0]  ERR_N   = ERR_THRESH[7:0];
    localparam logic [15:0] WIN_N   = WINDOW[15:0];

    state_e      state_q, state_d;
    logic        bypass_q, bypass_d;
    logic        vld_q, vld_d;
    logic        descr_rst_q, descr_rst_d;
    logic        locked_q, locked_d;
    logic [7:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  match_cnt_q, match_cnt_d;
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [7:0]  win_err_q, win_err_d;
    logic [7:0]  relock_cnt_q, relock_cnt_d;
    logic        is_match;
`ifdef PAD_DESCR_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
`endif

    function automatic logic is_active(input state_e s);
        return (s == ST_FLUSH) || (s == ST_HUNT) || (s == ST_LOCKED);
    endfunction

    // frame_in is a single-cycle qualifier (no backpressure): the descrambler shifts on
    // descr_frame, and descr_data is only meaningful in the following cycle while vld_q is high.
    assign is_match    = (descr_data == IDLE_WORD);
    assign descr_frame = frame_in & is_active(state_q);

    always_comb begin
        state_d      = state_q;
        bypass_d     = bypass_q;
        flush_cnt_d  = flush_cnt_q;
        match_cnt_d  = match_cnt_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        relock_cnt_d = relock_cnt_q;
`ifdef PAD_DESCR_ERRCNT_EN
        err_cnt_d    = err_cnt_q;
`endif
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_RESYNC: begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 8'd0;
                    if (state_q == ST_IDLE) bypass_d = bypass_req;
                end
                ST_FLUSH: begin
                    if (frame_in) begin
                        flush_cnt_d = flush_cnt_q + 8'd1;
                        if (flush_cnt_d == FLUSH_N) begin
                            state_d     = ST_HUNT;
                            match_cnt_d = 8'd0;
                        end
                    end
                end
                ST_HUNT: begin
                    if (vld_q) begin
                        match_cnt_d = is_match ? match_cnt_q + 8'd1 : 8'd0;
                        if (match_cnt_d == LOCK_N) begin
                            state_d   = ST_LOCKED;
                            win_cnt_d = 16'd0;
                            win_err_d = 8'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (vld_q) begin
                        win_cnt_d = win_cnt_q + 16'd1;
                        if (!is_match) begin
                            win_err_d = win_err_q + 8'd1;
`ifdef PAD_DESCR_ERRCNT_EN
                            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
`endif
                        end
                        // The word that hits the threshold wins over a window rollover.
                        if (win_err_d >= ERR_N) begin
                            state_d = ST_RESYNC;
                        end else if (win_cnt_d == WIN_N) begin
                            win_cnt_d = 16'd0;
                            win_err_d = 8'd0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (is_active(state_q) && (bypass_req != bypass_q)) begin
                state_d  = ST_RESYNC;
                bypass_d = bypass_req;
            end
            if ((state_d == ST_RESYNC) && (state_q != ST_RESYNC)) relock_cnt_d = relock_cnt_q + 8'd1;
        end
    end

    // Pipeline is dropped across any pass through IDLE/RESYNC so stale words are never compared.
    assign vld_d       = frame_in & is_active(state_q) & is_active(state_d);
    assign descr_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESYNC);
    assign locked_d    = (state_d == ST_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bypass_q     <= 1'b0;
            vld_q        <= 1'b0;
            descr_rst_q  <= 1'b1;
            locked_q     <= 1'b0;
            flush_cnt_q  <= 8'd0;
            match_cnt_q  <= 8'd0;
            win_cnt_q    <= 16'd0;
            win_err_q    <= 8'd0;
            relock_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            bypass_q     <= bypass_d;
            vld_q        <= vld_d;
            descr_rst_q  <= descr_rst_d;
            locked_q     <= locked_d;
            flush_cnt_q  <= flush_cnt_d;
            match_cnt_q  <= match_cnt_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            relock_cnt_q <= relock_cnt_d;
        end
    end

`ifdef PAD_DESCR_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= 16'd0;
        else     err_cnt_q <= err_cnt_d;
    end
    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0;
`endif

    assign state        = state_q;
    assign descr_rst    = descr_rst_q;
    assign descr_bypass = bypass_q;
    assign locked       = locked_q;
    assign relock_cnt   = relock_cnt_q;

endmodule
